myo_spi_scheduler: RTL and testbench

- Sequences all SPI traffic on one shared myocontrol SPI bus.
- Runs a periodic round-robin poll of every motor board and interleaves host-initiated transactions, with host requests taking priority.
- For each transaction it drives the one-hot active-low slave selects and handshakes a downstream SPI shift engine via start/done.
- Sits between the Avalon-facing myocontrol register logic and the SPI master core.

---
 rtl/myo_spi_scheduler_if.sv | 31 +++
 rtl/myo_spi_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_myo_spi_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/myo_spi_scheduler_if.sv
// Bundles the host request handshake and the SPI engine handshake/select lines.
// Latency: none (signal bundle only).
// Backpressure: host_req is a level held until host_ack; spi_start/spi_done are single pulses.
//
// master modport: the scheduler side. slave modport: host logic plus SPI engine.
//   host_req/host_motor -> scheduler, host_ack/host_err <- scheduler
//   spi_start/spi_motor/spi_is_host/ss_n <- scheduler, spi_done -> scheduler
interface myo_spi_scheduler_if #(
    parameter int NUMBER_OF_MOTORS = 9,
    parameter int MOTOR_W          = 4
);
    logic                        host_req;
    logic [MOTOR_W-1:0]          host_motor;
    logic                        host_ack;
    logic                        host_err;
    logic                        spi_start;
    logic [MOTOR_W-1:0]          spi_motor;
    logic                        spi_is_host;
    logic                        spi_done;
    logic [NUMBER_OF_MOTORS-1:0] ss_n;

    modport master (
        input  host_req, host_motor, spi_done,
        output host_ack, host_err, spi_start, spi_motor, spi_is_host, ss_n
    );

    modport slave (
        output host_req, host_motor, spi_done,
        input  host_ack, host_err, spi_start, spi_motor, spi_is_host, ss_n
    );
endinterface

// File: rtl/myo_spi_scheduler.sv
// Sequences a shared myocontrol SPI bus: periodic round-robin poll of all motor boards plus host transactions (host first).
// Latency: host request sampled at T -> ss_n low at T+1, spi_start at T+1+SETUP_CYCLES, host_ack HOLD_CYCLES after spi_done.
// Backpressure: host_req held until host_ack; one transaction in flight, waits on spi_done (optional watchdog MYO_SPI_WATCHDOG_EN).
//
// Ports: clock, reset (sync, active high); enable gates polling only; bus (myo_spi_scheduler_if.master)
// carries host request/ack and SPI engine handshake plus one-hot active-low ss_n; busy, round_done,
// overrun (sticky), timeout_err (sticky) and timeout_motor are status outputs.
// Macro MYO_SPI_WATCHDOG_EN: when defined, WAIT aborts after TIMEOUT_CYCLES without spi_done;
// when undefined WAIT waits forever and timeout_err/timeout_motor read 0.
// SETUP_CYCLES and HOLD_CYCLES must be >= 1.
module myo_spi_scheduler #(
    parameter int NUMBER_OF_MOTORS = 9,
    parameter int MOTOR_W          = 4,
    parameter int POLL_PERIOD      = 500000,
    parameter int SETUP_CYCLES     = 4,
    parameter int HOLD_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    myo_spi_scheduler_if.master bus,
    output logic               busy,
    output logic               round_done,
    output logic               overrun,
    output logic               timeout_err,
    output logic [MOTOR_W-1:0] timeout_motor
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    // One shared phase counter serves SELECT, RELEASE and the WAIT watchdog.
    localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int PER_W   = $clog2(POLL_PERIOD + 1);

    localparam logic [NUMBER_OF_MOTORS-1:0] SS_IDLE = '1;
    localparam logic [NUMBER_OF_MOTORS-1:0] SS_ONE  = NUMBER_OF_MOTORS'(1);

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [PER_W-1:0]   per_cnt;
    logic               round_active;
    logic [MOTOR_W-1:0] poll_idx;
    logic               rej_q;      // rejected host request, acked next cycle
    logic               ack_q;      // host_ack seen last cycle
    logic [MOTOR_W-1:0] motor_q;
    logic               is_host_q;
    logic [NUMBER_OF_MOTORS-1:0] ss_n_q;

    logic tick;
    logic rel_last;
    logic poll_adv;
    logic host_pick;
    logic host_bad;
    logic host_ack_c;

    assign tick     = enable && (per_cnt == PER_W'(POLL_PERIOD - 1));
    assign rel_last = (state == S_RELEASE) && (cnt == CNT_W'(HOLD_CYCLES - 1));
    // A poll completion only advances the round while polling is still enabled;
    // dropping enable abandons the round silently.
    assign poll_adv = rel_last && !is_host_q && round_active && enable;

    assign host_ack_c = (rel_last && is_host_q) || rej_q;
    // Ignore host_req while the ack of the previous request is still visible,
    // so a host that drops req one cycle after ack is not served twice.
    assign host_pick  = bus.host_req && !host_ack_c && !ack_q;
    assign host_bad   = 32'(bus.host_motor) >= NUMBER_OF_MOTORS;

    assign bus.host_ack    = host_ack_c;
    assign bus.host_err    = rej_q;
    assign bus.spi_start   = (state == S_START);
    assign bus.spi_motor   = motor_q;
    assign bus.spi_is_host = is_host_q;
    assign bus.ss_n        = ss_n_q;
    assign busy            = (state != S_IDLE);
    assign round_done      = poll_adv && (poll_idx == MOTOR_W'(NUMBER_OF_MOTORS - 1));

`ifndef MYO_SPI_WATCHDOG_EN
    assign timeout_err   = 1'b0;
    assign timeout_motor = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            per_cnt      <= '0;
            round_active <= 1'b0;
            poll_idx     <= '0;
            rej_q        <= 1'b0;
            ack_q        <= 1'b0;
            motor_q      <= '0;
            is_host_q    <= 1'b0;
            ss_n_q       <= SS_IDLE;
            overrun      <= 1'b0;
`ifdef MYO_SPI_WATCHDOG_EN
            timeout_err   <= 1'b0;
            timeout_motor <= '0;
`endif
        end else begin
            rej_q <= 1'b0;
            ack_q <= host_ack_c;

            // Poll period timebase; held at zero while polling is disabled.
            if (!enable || tick) begin
                per_cnt <= '0;
            end else begin
                per_cnt <= per_cnt + 1'b1;
            end

            if (!enable) begin
                round_active <= 1'b0;
                poll_idx     <= '0;
            end else begin
                if (poll_adv) begin
                    if (poll_idx == MOTOR_W'(NUMBER_OF_MOTORS - 1)) begin
                        round_active <= 1'b0;
                        poll_idx     <= '0;
                    end else begin
                        poll_idx <= poll_idx + 1'b1;
                    end
                end
                // poll_adv requires round_active, so it never collides with a round start.
                if (tick) begin
                    if (!round_active) begin
                        round_active <= 1'b1;
                        poll_idx     <= '0;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (host_pick) begin
                        if (host_bad) begin
                            rej_q <= 1'b1;
                        end else begin
                            motor_q   <= bus.host_motor;
                            is_host_q <= 1'b1;
                            ss_n_q    <= ~(SS_ONE << bus.host_motor);
                            state     <= S_SELECT;
                        end
                    end else if (round_active && enable) begin
                        motor_q   <= poll_idx;
                        is_host_q <= 1'b0;
                        ss_n_q    <= ~(SS_ONE << poll_idx);
                        state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.spi_done) begin
                        cnt   <= '0;
                        state <= S_RELEASE;
`ifdef MYO_SPI_WATCHDOG_EN
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err   <= 1'b1;
                        timeout_motor <= motor_q;
                        cnt           <= '0;
                        state         <= S_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                S_RELEASE: begin
                    if (rel_last) begin
                        cnt    <= '0;
                        ss_n_q <= SS_IDLE;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt    <= '0;
                    ss_n_q <= SS_IDLE;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Directed bench for myo_spi_scheduler with a simple SPI engine model and activity monitor.
// Latency: n/a.
// Backpressure: engine replies spi_done eng_lat cycles after spi_start (never when hung).
module tb_myo_spi_scheduler;
    localparam int NM = 9;
    localparam int MW = 4;
    localparam int PP = 200;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          busy, round_done, overrun, timeout_err;
    logic [MW-1:0] timeout_motor;

    myo_spi_scheduler_if #(.NUMBER_OF_MOTORS(NM), .MOTOR_W(MW)) bus_if ();

    myo_spi_scheduler #(
        .NUMBER_OF_MOTORS(NM), .MOTOR_W(MW), .POLL_PERIOD(PP),
        .SETUP_CYCLES(4), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .bus(bus_if),
        .busy(busy), .round_done(round_done), .overrun(overrun),
        .timeout_err(timeout_err), .timeout_motor(timeout_motor)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // SPI engine model
    int eng_lat = 10;
    int hang_motor = -1;
    int start_cyc = 0;
    int done_cyc = 0;
    bit eng_abort;

    initial begin
        bus_if.spi_done = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (bus_if.spi_start) begin
                start_cyc = cyc;
                eng_abort = (eng_lat == 0) || (int'(bus_if.spi_motor) == hang_motor);
                if (!eng_abort) begin
                    for (int i = 0; i < eng_lat; i++) begin
                        @(posedge clock);
                        if (reset) eng_abort = 1'b1;
                    end
                    #1;
                    if (!eng_abort) begin
                        bus_if.spi_done = 1'b1;
                        done_cyc = cyc;
                        @(posedge clock); #1;
                        bus_if.spi_done = 1'b0;
                    end
                end
            end
        end
    end

    // Activity monitor: start log (motor + 16 for host), round_done count, multi-select count
    int mq[$];
    int rd_cnt = 0;
    int ss_viol = 0;

    initial begin
        forever begin
            @(posedge clock); #1;
            if (bus_if.spi_start) mq.push_back(int'(bus_if.spi_motor) + (bus_if.spi_is_host ? 16 : 0));
            if (round_done) rd_cnt++;
            if ($countones(~bus_if.ss_n) > 1) ss_viol++;
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) step();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL wait_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        bus_if.host_req = 1'b0; bus_if.host_motor = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (bus_if.ss_n !== 9'h1FF) begin n_bad++; $display("FAIL reset_ss_n: got %h want 1ff", bus_if.ss_n); end
        n_cmp++;
        if ({busy, bus_if.host_ack, bus_if.host_err, bus_if.spi_start, round_done, overrun, timeout_err, bus_if.spi_is_host} !== 8'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {busy, bus_if.host_ack, bus_if.host_err, bus_if.spi_start, round_done, overrun, timeout_err, bus_if.spi_is_host});
        end
        n_cmp++;
        if (bus_if.spi_motor !== 4'd0) begin n_bad++; $display("FAIL reset_spi_motor: got %0d want 0", bus_if.spi_motor); end
        n_cmp++;
        if (timeout_motor !== 4'd0) begin n_bad++; $display("FAIL reset_timeout_motor: got %0d want 0", timeout_motor); end
    endtask

    task automatic test_host_txn();
        int t, s, bad;
        bad = 0;
        eng_lat = 20;
        bus_if.host_motor = 4'd3; bus_if.host_req = 1'b1;
        t = cyc;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus_if.ss_n !== 9'h1F7) bad++;
            if (bus_if.spi_start) break;
        end
        s = cyc;
        n_cmp++;
        if (bus_if.spi_start !== 1'b1 || s != t + 5) begin
            n_bad++; $display("FAIL host_start_cycle: got %0d want %0d", s - t, 5);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus_if.ss_n !== 9'h1F7) bad++;
            if (bus_if.host_ack) break;
        end
        n_cmp++;
        if (done_cyc != s + 20) begin n_bad++; $display("FAIL host_done_cycle: got %0d want %0d", done_cyc - s, 20); end
        n_cmp++;
        if (bus_if.host_ack !== 1'b1 || cyc != done_cyc + 4) begin
            n_bad++; $display("FAIL host_ack_cycle: ack=%b delay %0d want 4", bus_if.host_ack, cyc - done_cyc);
        end
        n_cmp++;
        if ({bus_if.spi_is_host, bus_if.spi_motor, bus_if.host_err} !== {1'b1, 4'd3, 1'b0}) begin
            n_bad++; $display("FAIL host_attrs: is_host=%b motor=%0d err=%b want 1 3 0", bus_if.spi_is_host, bus_if.spi_motor, bus_if.host_err);
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL host_ss_n: %0d cycles not 1f7, want 0", bad); end
        bus_if.host_req = 1'b0;
        step();
        n_cmp++;
        if (bus_if.ss_n !== 9'h1FF || busy !== 1'b0) begin
            n_bad++; $display("FAIL host_release: ss_n=%h busy=%b want 1ff 0", bus_if.ss_n, busy);
        end
    endtask

    task automatic test_poll_round();
        mq.delete(); rd_cnt = 0; eng_lat = 10; enable = 1'b1;
        for (int i = 0; i < 600 && !round_done; i++) step();
        n_cmp++;
        if (round_done !== 1'b1) begin n_bad++; $display("FAIL poll_round_done: got %b want 1", round_done); end
        enable = 1'b0;
        n_cmp++;
        if (mq.size() != 9) begin n_bad++; $display("FAIL poll_count: got %0d want 9", mq.size()); end
        for (int i = 0; i < 9 && i < mq.size(); i++) begin
            n_cmp++;
            if (mq[i] != i) begin n_bad++; $display("FAIL poll_order[%0d]: got %0d want %0d", i, mq[i], i); end
        end
        repeat (10) step();
        n_cmp++;
        if (rd_cnt != 1 || overrun !== 1'b0) begin
            n_bad++; $display("FAIL poll_single_round: round_done=%0d overrun=%b want 1 0", rd_cnt, overrun);
        end
        wait_idle();
    endtask

    task automatic test_interleave();
        int exp_seq[10];
        exp_seq = '{0, 1, 2, 23, 3, 4, 5, 6, 7, 8};
        mq.delete(); rd_cnt = 0; eng_lat = 8; enable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus_if.spi_start && bus_if.spi_motor == 4'd2 && !bus_if.spi_is_host) break;
        end
        bus_if.host_motor = 4'd7; bus_if.host_req = 1'b1;
        for (int i = 0; i < 200 && !bus_if.host_ack; i++) step();
        n_cmp++;
        if (bus_if.host_ack !== 1'b1 || bus_if.host_err !== 1'b0) begin
            n_bad++; $display("FAIL inter_ack: ack=%b err=%b want 1 0", bus_if.host_ack, bus_if.host_err);
        end
        bus_if.host_req = 1'b0;
        for (int i = 0; i < 400 && !round_done; i++) step();
        enable = 1'b0;
        n_cmp++;
        if (mq.size() != 10) begin n_bad++; $display("FAIL inter_count: got %0d want 10", mq.size()); end
        for (int i = 0; i < 10 && i < mq.size(); i++) begin
            n_cmp++;
            if (mq[i] != exp_seq[i]) begin n_bad++; $display("FAIL inter_order[%0d]: got %0d want %0d", i, mq[i], exp_seq[i]); end
        end
        wait_idle();
    endtask

    task automatic test_reject();
        mq.delete();
        bus_if.host_motor = 4'd12; bus_if.host_req = 1'b1;
        step();
        n_cmp++;
        if ({bus_if.host_ack, bus_if.host_err, busy} !== 3'b110 || bus_if.ss_n !== 9'h1FF) begin
            n_bad++; $display("FAIL reject_pulse: ack=%b err=%b busy=%b ss_n=%h want 1 1 0 1ff",
                              bus_if.host_ack, bus_if.host_err, busy, bus_if.ss_n);
        end
        bus_if.host_req = 1'b0;
        step();
        n_cmp++;
        if ({bus_if.host_ack, bus_if.host_err} !== 2'b00) begin
            n_bad++; $display("FAIL reject_single: ack=%b err=%b want 0 0", bus_if.host_ack, bus_if.host_err);
        end
        repeat (4) step();
        n_cmp++;
        if (mq.size() != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL reject_no_txn: starts=%0d busy=%b want 0 0", mq.size(), busy); end
    endtask

    task automatic test_overrun();
        int e;
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_pre: got %b want 0", overrun); end
        rd_cnt = 0; eng_lat = 30; enable = 1'b1;
        e = cyc;
        for (int i = 0; i < 450 && !overrun; i++) step();
        n_cmp++;
        if (overrun !== 1'b1 || cyc != e + 2 * PP) begin
            n_bad++; $display("FAIL overrun_cycle: overrun=%b at +%0d want 1 at +%0d", overrun, cyc - e, 2 * PP);
        end
        enable = 1'b0;
        wait_idle();
        repeat (5) step();
        n_cmp++;
        if (overrun !== 1'b1 || rd_cnt != 0) begin
            n_bad++; $display("FAIL overrun_sticky: overrun=%b round_done=%0d want 1 0", overrun, rd_cnt);
        end
    endtask

    task automatic test_watchdog();
`ifdef MYO_SPI_WATCHDOG_EN
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL wd_pre: timeout_err=%b want 0", timeout_err); end
        mq.delete(); eng_lat = 10; hang_motor = 5; enable = 1'b1;
        for (int i = 0; i < 800 && !timeout_err; i++) step();
        n_cmp++;
        if (timeout_err !== 1'b1 || timeout_motor !== 4'd5 || cyc != start_cyc + 65) begin
            n_bad++; $display("FAIL wd_timeout: err=%b motor=%0d delay=%0d want 1 5 65", timeout_err, timeout_motor, cyc - start_cyc);
        end
        for (int i = 0; i < 600 && !round_done; i++) step();
        enable = 1'b0; hang_motor = -1;
        n_cmp++;
        if (mq.size() != 9 || mq[5] != 5 || mq[6] != 6) begin
            n_bad++; $display("FAIL wd_continue: starts=%0d m5=%0d m6=%0d want 9 5 6", mq.size(), mq[5], mq[6]);
        end
        wait_idle();
`else
        int idle_cycles;
        idle_cycles = 0;
        mq.delete(); eng_lat = 10; hang_motor = 0; enable = 1'b1;
        for (int i = 0; i < 300 && !bus_if.spi_start; i++) step();
        n_cmp++;
        if (bus_if.spi_start !== 1'b1 || bus_if.spi_motor !== 4'd0) begin
            n_bad++; $display("FAIL wd_first_motor: start=%b motor=%0d want 1 0", bus_if.spi_start, bus_if.spi_motor);
        end
        enable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!busy) idle_cycles++;
        end
        n_cmp++;
        if (idle_cycles != 0 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL wd_hang: idle_cycles=%0d timeout_err=%b want 0 0", idle_cycles, timeout_err);
        end
        reset = 1'b1; step(); reset = 1'b0; hang_motor = -1; step();
`endif
    endtask

    task automatic test_reset_in_wait();
        eng_lat = 0;
        bus_if.host_motor = 4'd1; bus_if.host_req = 1'b1;
        for (int i = 0; i < 20 && !bus_if.spi_start; i++) step();
        repeat (3) step();
        n_cmp++;
        if (busy !== 1'b1 || bus_if.ss_n !== 9'h1FD) begin
            n_bad++; $display("FAIL rst_pre: busy=%b ss_n=%h want 1 1fd", busy, bus_if.ss_n);
        end
        reset = 1'b1; bus_if.host_req = 1'b0;
        step();
        n_cmp++;
        if (bus_if.ss_n !== 9'h1FF || {busy, bus_if.spi_start, bus_if.host_ack, bus_if.host_err, round_done, overrun} !== 6'b0) begin
            n_bad++; $display("FAIL rst_wait: ss_n=%h flags=%b want 1ff 000000", bus_if.ss_n,
                              {busy, bus_if.spi_start, bus_if.host_ack, bus_if.host_err, round_done, overrun});
        end
        reset = 1'b0;
        step();
        eng_lat = 10; bus_if.host_motor = 4'd4; bus_if.host_req = 1'b1;
        for (int i = 0; i < 100 && !bus_if.host_ack; i++) step();
        n_cmp++;
        if (bus_if.host_ack !== 1'b1 || bus_if.spi_motor !== 4'd4 || bus_if.host_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_after_host: ack=%b motor=%0d err=%b want 1 4 0", bus_if.host_ack, bus_if.spi_motor, bus_if.host_err);
        end
        bus_if.host_req = 1'b0;
        step();
        n_cmp++;
        if (bus_if.ss_n !== 9'h1FF || ss_viol != 0) begin
            n_bad++; $display("FAIL final_ss: ss_n=%h multi_select=%0d want 1ff 0", bus_if.ss_n, ss_viol);
        end
    endtask

    initial begin
        test_reset();
        test_host_txn();
        test_poll_round();
        test_interleave();
        test_reject();
        test_overrun();
        test_watchdog();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
